// File: rtl/div_clock_monitor.sv
// Fast-domain monitor for a divided clock: synchronised edge strobes, rise-to-rise
// period measurement, lock detection on a stable period and loss detection on timeout.
module div_clock_monitor #(
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1024,
  parameter int LOCK_COUNT = 4,
  parameter int TOL        = 0
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             div_clock,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lost
);

  typedef enum logic [2:0] {S_IDLE, S_MEASURE, S_CHECK, S_LOCKED, S_LOST} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_LAST = 4'(LOCK_COUNT - 1);
  localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic within_tol(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic signed [CNT_W+1:0] d;
    d = $signed({2'b00, a}) - $signed({2'b00, b});
    if (d < 0) d = -d;
    return d <= $signed({1'b0, TOL_C});
  endfunction

  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_cnt, r_ref;
  logic [3:0]       r_match;
  state_t           r_state;

  state_t     w_state_nxt;
  logic [3:0] w_match_nxt;
  logic       w_rise, w_fall, w_report, w_match_ok;

  assign w_rise     = r_s2 & ~r_s3;
  assign w_fall     = ~r_s2 & r_s3;
  // r_cnt still holds the pre-load count on the rise cycle, so it is the measured period
  assign w_match_ok = within_tol(r_cnt, r_ref);

  always_ff @(posedge clock_in) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_match_nxt = r_match;
    w_report    = 1'b0;
    case (r_state)
      S_IDLE, S_LOST: begin
        if (w_rise) w_state_nxt = S_MEASURE;
      end
      S_MEASURE: begin
        if (w_rise) begin
          w_report    = 1'b1;
          w_match_nxt = '0;
          w_state_nxt = (LOCK_COUNT == 1) ? S_LOCKED : S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_rise) begin
          w_report = 1'b1;
          if (w_match_ok) begin
            w_match_nxt = r_match + 4'd1;
            if (w_match_nxt >= LOCK_LAST) w_state_nxt = S_LOCKED;
          end else begin
            w_match_nxt = '0;
          end
        end
      end
      S_LOCKED: begin
        if (w_rise) begin
          w_report = 1'b1;
          if (!w_match_ok) begin
            w_match_nxt = '0;
            w_state_nxt = S_CHECK;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A rise in the same cycle as the timeout takes priority
    if (!w_rise && (r_state != S_LOST) && (r_cnt == TIMEOUT_C)) w_state_nxt = S_LOST;
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_s1         <= 1'b0;
      r_s2         <= 1'b0;
      r_s3         <= 1'b0;
      r_cnt        <= '0;
      r_ref        <= '0;
      r_match      <= '0;
      period       <= '0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else begin
      r_s1         <= div_clock;
      r_s2         <= r_s1;
      r_s3         <= r_s2;
      rise_pulse   <= w_rise;
      fall_pulse   <= w_fall;
      r_cnt        <= w_rise ? CNT_W'(1) : sat_inc(r_cnt);
      r_match      <= w_match_nxt;
      period_valid <= w_report;
      if (w_report) begin
        period <= r_cnt;
        r_ref  <= r_cnt;
      end
      locked <= (r_state == S_LOCKED);
      lost   <= (r_state == S_LOST);
    end
  end

endmodule

// File: tb/tb_div_clock_monitor.sv
// Randomised scoreboard bench for div_clock_monitor: two instances (TOL 0 and TOL 2)
// share one input stream and are checked against an edge-level reference model.
module tb_div_clock_monitor;

  localparam int CNT_W      = 16;
  localparam int TIMEOUT    = 1024;
  localparam int LOCK_COUNT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic div_clock = 1'b0;

  logic             rise0, fall0, pv0, lk0, ls0;
  logic             rise1, fall1, pv1, lk1, ls1;
  logic [CNT_W-1:0] per0, per1;

  always #5 clk = ~clk;

  div_clock_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .LOCK_COUNT(LOCK_COUNT), .TOL(0)) u_dut0 (
    .clock_in(clk), .reset(reset), .div_clock(div_clock),
    .rise_pulse(rise0), .fall_pulse(fall0), .period(per0), .period_valid(pv0),
    .locked(lk0), .lost(ls0)
  );

  div_clock_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .LOCK_COUNT(LOCK_COUNT), .TOL(2)) u_dut1 (
    .clock_in(clk), .reset(reset), .div_clock(div_clock),
    .rise_pulse(rise1), .fall_pulse(fall1), .period(per1), .period_valid(pv1),
    .locked(lk1), .lost(ls1)
  );

  typedef struct {
    int cyc;
    int per;
  } rep_t;

  rep_t q0[$];
  rep_t q1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 0;

  // expected outputs after the most recent clock edge
  bit exp_rst, exp_rise, exp_fall, exp_lost;
  bit exp_lk[2];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference model: works on input samples and rise times, not on counters or states.
  initial begin : model
    bit h0, h1, h2, h3;
    bit have_edge, have_prev, m_lost;
    bit m_lk[2];
    int run[2];
    int last, prev, p;
    forever begin
      @(posedge clk);
      cyc++;
      started = 1;
      if (reset) begin
        {h0, h1, h2, h3} = 4'b0;
        have_edge = 0; have_prev = 0; m_lost = 0;
        m_lk[0] = 0; m_lk[1] = 0; run[0] = 0; run[1] = 0;
        last = cyc + 1;
        exp_rst = 1; exp_rise = 0; exp_fall = 0; exp_lost = 0;
        exp_lk[0] = 0; exp_lk[1] = 0;
      end else begin
        exp_rst = 0;
        h3 = h2; h2 = h1; h1 = h0; h0 = div_clock;
        exp_rise = h2 & ~h3;
        exp_fall = ~h2 & h3;
        exp_lk[0] = m_lk[0];
        exp_lk[1] = m_lk[1];
        exp_lost = m_lost;
        if (exp_rise) begin
          if (have_edge && !m_lost) begin
            p = cyc - last;
            q0.push_back('{cyc, p});
            q1.push_back('{cyc, p});
            for (int i = 0; i < 2; i++) begin
              if (have_prev && iabs(p - prev) <= ((i == 1) ? 2 : 0)) run[i]++;
              else run[i] = 1;
              m_lk[i] = (run[i] >= LOCK_COUNT);
            end
            have_prev = 1;
            prev = p;
          end
          have_edge = 1;
          m_lost = 0;
          last = cyc;
        end else if (!m_lost && (cyc - last == TIMEOUT)) begin
          m_lost = 1; have_edge = 0; have_prev = 0;
          m_lk[0] = 0; m_lk[1] = 0; run[0] = 0; run[1] = 0;
        end
      end
    end
  end

  initial begin : monitor
    rep_t e;
    forever begin
      @(negedge clk);
      if (started) begin
        chk("rise0", rise0, exp_rise);
        chk("fall0", fall0, exp_fall);
        chk("lost0", ls0, exp_lost);
        chk("locked0", lk0, exp_lk[0]);
        chk("rise1", rise1, exp_rise);
        chk("fall1", fall1, exp_fall);
        chk("lost1", ls1, exp_lost);
        chk("locked1", lk1, exp_lk[1]);
        if (exp_rst) begin
          chk("reset_period0", per0, 0);
          chk("reset_pv0", pv0, 0);
          chk("reset_period1", per1, 0);
        end
        if (q0.size() > 0 && q0[0].cyc < cyc) begin
          e = q0.pop_front();
          chk("pv0_missing_at_cycle", cyc, e.cyc);
        end
        if (pv0) begin
          if (q0.size() == 0) chk("pv0_unexpected", 1, 0);
          else begin
            e = q0.pop_front();
            chk("pv0_cycle", cyc, e.cyc);
            chk("period0", per0, e.per);
          end
        end
        if (q1.size() > 0 && q1[0].cyc < cyc) begin
          e = q1.pop_front();
          chk("pv1_missing_at_cycle", cyc, e.cyc);
        end
        if (pv1) begin
          if (q1.size() == 0) chk("pv1_unexpected", 1, 0);
          else begin
            e = q1.pop_front();
            chk("pv1_cycle", cyc, e.cyc);
            chk("period1", per1, e.per);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
    $fatal(1);
  end

  task automatic step(input logic d, input logic r);
    @(negedge clk);
    div_clock = d;
    reset = r;
  endtask

  task automatic drive_period(input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
    for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
  endtask

  initial begin : stim
    int p, reps, pi, hi;
    repeat (3) step(1'b0, 1'b1);
    // divide-by-4, lock
    repeat (12) drive_period(2, 2);
    // one period of 6, then relock on 4
    drive_period(3, 3);
    repeat (6) drive_period(2, 2);
    // random period blocks with +/-1 jitter
    for (int b = 0; b < 20; b++) begin
      p = $urandom_range(5, 9);
      reps = $urandom_range(1, 7);
      for (int r = 0; r < reps; r++) begin
        pi = p + $urandom_range(0, 2) - 1;
        if ($urandom_range(0, 1) == 0) pi = p;
        hi = $urandom_range(2, pi - 2);
        drive_period(hi, pi - hi);
      end
    end
    repeat (8) drive_period(2, 2);
    // stopped clock, then restart from lost
    repeat (1100) step(1'b0, 1'b0);
    repeat (8) drive_period(2, 2);
    // reset while locked, then relock
    step(1'b0, 1'b1);
    repeat (8) drive_period(2, 2);
    // reset released while div_clock is high
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    repeat (8) drive_period(2, 2);
    repeat (10) step(1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
